// File: rtl/mesh_mv_top.sv
// mesh_mv_top: weight-stationary matrix-vector multiply engine.
// A ROWS x COLS unsigned weight array is preloaded one element per cycle.
// A start pulse latches the input vector, then all rows accumulate one
// column per cycle. The finished dot products are published on result_flat.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; the only state that accepts weight writes
// LOAD_X | x register holds the new vector, accumulators are cleared
// MAC    | COLS cycles; cycle k adds w[r][k]*x[k] into every acc[r]
// STORE  | accumulators copied to result_flat, then back to IDLE
module mesh_mv_top #(
    parameter int DW      = 8,
    parameter int ROWS    = 5,
    parameter int COLS    = 5,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3,
    parameter int CYCLE_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     preload_valid,
    input  logic [ROW_W+COL_W-1:0]   preload_addr,
    input  logic [DW-1:0]            preload_data,
    input  logic [COLS*DW-1:0]       x_vector_flat,
    output logic [ROWS*2*DW-1:0]     result_flat
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_X = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_STORE  = 2'd3;

    logic [1:0]          state;
    logic [CYCLE_W-1:0]  cycle;
    logic [DW-1:0]       w     [ROWS][COLS];
    logic [DW-1:0]       x_reg [COLS];
    logic [2*DW-1:0]     acc   [ROWS];

    logic [ROW_W-1:0]    pl_row;
    logic [COL_W-1:0]    pl_col;
    logic                pl_en;
    logic [DW-1:0]       x_sel;
    logic [DW-1:0]       w_sel [ROWS];
    logic                last_mac;

    assign pl_row   = preload_addr[ROW_W+COL_W-1:COL_W];
    assign pl_col   = preload_addr[COL_W-1:0];
    assign pl_en    = preload_valid && (state == S_IDLE);
    assign last_mac = (cycle == CYCLE_W'(COLS - 1));

    // Weight store: addressed writes in IDLE only; out-of-range addresses
    // match no element and therefore fall through harmlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    w[r][c] <= '0;
                end
            end
        end else if (pl_en) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (pl_row == ROW_W'(r) && pl_col == COL_W'(c)) begin
                        w[r][c] <= preload_data;
                    end
                end
            end
        end
    end

    // Column select for the current MAC cycle: one x element and the
    // matching weight column for all rows.
    always_comb begin
        x_sel = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_sel[r] = '0;
        end
        for (int c = 0; c < COLS; c++) begin
            if (cycle == CYCLE_W'(c)) begin
                x_sel = x_reg[c];
                for (int r = 0; r < ROWS; r++) begin
                    w_sel[r] = w[r][c];
                end
            end
        end
    end

    // Sequencer and datapath: vector latch, accumulation, result publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cycle       <= '0;
            result_flat <= '0;
            for (int c = 0; c < COLS; c++) begin
                x_reg[c] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                acc[r] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < COLS; c++) begin
                            x_reg[c] <= x_vector_flat[c*DW +: DW];
                        end
                        for (int r = 0; r < ROWS; r++) begin
                            acc[r] <= '0;
                        end
                        cycle <= '0;
                        state <= S_LOAD_X;
                    end
                end
                S_LOAD_X: begin
                    cycle <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    // Products are full 2*DW wide; the sum wraps at 2*DW bits.
                    for (int r = 0; r < ROWS; r++) begin
                        acc[r] <= acc[r] + ((2*DW)'(w_sel[r]) * (2*DW)'(x_sel));
                    end
                    cycle <= cycle + CYCLE_W'(1);
                    if (last_mac) begin
                        state <= S_STORE;
                    end
                end
                S_STORE: begin
                    for (int r = 0; r < ROWS; r++) begin
                        result_flat[r*2*DW +: 2*DW] <= acc[r];
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_mv_top.sv
// Testbench for mesh_mv_top: directed vectors, scoreboard queue of expected
// result_flat values with the edge at which each must appear.
module tb_mesh_mv_top;

    localparam int DW   = 8;
    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int RW   = ROWS * 2 * DW;
    localparam int XW   = COLS * DW;
    localparam int LAT  = COLS + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           preload_valid = 1'b0;
    logic [5:0]     preload_addr = '0;
    logic [DW-1:0]  preload_data = '0;
    logic [XW-1:0]  x_vector_flat = '0;
    logic [RW-1:0]  result_flat;

    typedef struct {
        logic [RW-1:0] exp;
        logic [RW-1:0] hold;
        int            start;
        int            lat;
        string         name;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    logic [RW-1:0] last_exp = '0;

    localparam logic [XW-1:0] X_SEQ  = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [XW-1:0] X_ZERO = '0;
    localparam logic [XW-1:0] X_ONE  = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [XW-1:0] X_FF   = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    localparam logic [RW-1:0] R_SEQ  = {16'd115, 16'd100, 16'd85, 16'd70, 16'd55};
    localparam logic [RW-1:0] R_ONE  = {16'd35, 16'd30, 16'd25, 16'd20, 16'd15};
    // 5*65025 = 325125; mod 65536 = 62981
    localparam logic [RW-1:0] R_OVF  = {16'd62981, 16'd62981, 16'd62981, 16'd62981, 16'd62981};

    mesh_mv_top dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .preload_valid (preload_valid),
        .preload_addr  (preload_addr),
        .preload_data  (preload_data),
        .x_vector_flat (x_vector_flat),
        .result_flat   (result_flat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: holds the previous value before the due edge, checks the new
    // value at the due edge, pops the entry.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb[0];
                if (cyc >= e.start && cyc < e.start + e.lat) begin
                    total++;
                    if (result_flat !== e.hold) begin
                        bad++;
                        $display("FAIL %s early_change cyc=%0d got=%h want=%h", e.name, cyc, result_flat, e.hold);
                    end
                end else if (cyc == e.start + e.lat) begin
                    total++;
                    if (result_flat !== e.exp) begin
                        bad++;
                        $display("FAIL %s result cyc=%0d got=%h want=%h", e.name, cyc, result_flat, e.exp);
                    end
                    void'(sb.pop_front());
                end else if (cyc > e.start + e.lat) begin
                    total++;
                    bad++;
                    $display("FAIL %s missed_check cyc=%0d got=%h want=%h", e.name, cyc, result_flat, e.exp);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic preload(input logic [2:0] r, input logic [2:0] c, input logic [DW-1:0] d);
        preload_valid = 1'b1;
        preload_addr  = {r, c};
        preload_data  = d;
        @(negedge clk);
        preload_valid = 1'b0;
    endtask

    task automatic preload_ramp();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                preload(3'(r), 3'(c), DW'(r + c + 1));
            end
        end
    endtask

    // Called at a negedge; returns at the negedge right after the STORE edge,
    // so consecutive calls exercise back-to-back starts.
    task automatic run(input logic [XW-1:0] xv, input logic [RW-1:0] exp, input string nm);
        int launch;
        launch = cyc + 1;
        start = 1'b1;
        x_vector_flat = xv;
        sb.push_back('{exp, last_exp, launch, LAT, nm});
        @(negedge clk);
        start = 1'b0;
        while (cyc < launch + LAT) @(negedge clk);
        last_exp = exp;
    endtask

    initial begin
        int launch;

        repeat (3) @(negedge clk);
        sb.push_back('{'0, '0, cyc + 1, 0, "reset"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        preload_ramp();
        run(X_SEQ, R_SEQ, "ramp_seq");
        run(X_ZERO, '0, "ramp_zero");
        run(X_ONE, R_ONE, "ramp_ones");

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                preload(3'(r), 3'(c), 8'd255);
            end
        end
        run(X_FF, R_OVF, "overflow");

        preload(3'd6, 3'd0, 8'd0);
        preload(3'd5, 3'd1, 8'd0);
        preload(3'd0, 3'd7, 8'd0);
        preload(3'd7, 3'd7, 8'd0);
        preload(3'd2, 3'd5, 8'd0);
        run(X_FF, R_OVF, "bad_addr");

        // Clean ramp run, but with a weight write, a new start and a new
        // x vector thrown at the engine during MAC.
        preload_ramp();
        launch = cyc + 1;
        start = 1'b1;
        x_vector_flat = X_SEQ;
        sb.push_back('{R_SEQ, last_exp, launch, LAT, "disturb"});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        preload_valid = 1'b1;
        preload_addr = {3'd0, 3'd0};
        preload_data = 8'd99;
        x_vector_flat = X_FF;
        @(negedge clk);
        start = 1'b0;
        preload_valid = 1'b0;
        while (cyc < launch + LAT) @(negedge clk);
        last_exp = R_SEQ;
        run(X_ONE, R_ONE, "after_disturb");

        // Reset in the middle of MAC, then a rerun without preload.
        launch = cyc + 1;
        start = 1'b1;
        x_vector_flat = X_SEQ;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        sb.delete();
        sb.push_back('{'0, '0, cyc + 1, 0, "rst_mid"});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        run(X_SEQ, '0, "rerun_zero_w");
        run(X_ONE, '0, "rerun_zero_w2");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
